// File: rtl/tetromino_render.sv
// Tetromino renderer: a load strobe latches piece/rotation/anchor, a 4-cycle build fills a shadow cell set,
// and the set is committed atomically. A 2-stage pipeline then classifies each pixel as inner, edge or miss.
module tetromino_render #(
    parameter int SIZE    = 16,
    parameter int EDGE    = 1,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [2:0]         piece,
    input  logic [1:0]         rot,
    input  logic [COORD_W-1:0] ref_x,
    input  logic [COORD_W-1:0] ref_y,
    input  logic [COORD_W-1:0] addr_x,
    input  logic [COORD_W-1:0] addr_y,
    output logic               en_inner,
    output logic               en_edge,
    output logic               busy,
    output logic               done
);

    // Origins carry two extra bits so that anchors near the screen limit never wrap back on-screen.
    localparam int XW = COORD_W + 2;

    typedef enum logic [1:0] {IDLE, BUILD, ACTIVE} state_t;

    typedef struct packed {
        logic          vld;
        logic [XW-1:0] x0;
        logic [XW-1:0] y0;
    } cell_t;

    state_t               state_q, state_d;
    logic   [1:0]         k_q, k_d;
    logic   [2:0]         piece_q, piece_d;
    logic   [1:0]         rot_q, rot_d;
    logic   [COORD_W-1:0] ref_x_q, ref_x_d;
    logic   [COORD_W-1:0] ref_y_q, ref_y_d;
    cell_t  [3:0]         shadow_q, shadow_d;
    cell_t  [3:0]         active_q, active_d;
    logic                 active_valid_q, active_valid_d;
    logic                 done_q, done_d;
    logic   [3:0]         hit_q, hit_d;
    logic   [3:0]         bnd_q, bnd_d;
    logic                 en_inner_q, en_inner_d;
    logic                 en_edge_q, en_edge_d;
    logic                 commit;
    cell_t                new_cell;

    // Rotation-0 cell k of a piece as {col,row}; cell 0 sits in the low nibble.
    function automatic logic [3:0] base_cell(input logic [2:0] p, input logic [1:0] idx);
        logic [15:0] tbl;
        case (p)
            3'd0:    tbl = {4'b1101, 4'b1001, 4'b0101, 4'b0001}; // I
            3'd1:    tbl = {4'b1001, 4'b0101, 4'b1000, 4'b0100}; // O
            3'd2:    tbl = {4'b1001, 4'b0101, 4'b0001, 4'b0100}; // T
            3'd3:    tbl = {4'b0101, 4'b0001, 4'b1000, 4'b0100}; // S
            3'd4:    tbl = {4'b1001, 4'b0101, 4'b0100, 4'b0000}; // Z
            3'd5:    tbl = {4'b1001, 4'b0101, 4'b0001, 4'b0000}; // J
            3'd6:    tbl = {4'b1001, 4'b0101, 4'b0001, 4'b1000}; // L
            default: tbl = '0;
        endcase
        return tbl[idx*4 +: 4];
    endfunction

    // Clockwise quarter-turn (c,r) -> (3-r,c), pre-composed for 0..3 turns.
    function automatic logic [3:0] rotate(input logic [3:0] cr, input logic [1:0] turns);
        logic [1:0] c;
        logic [1:0] r;
        c = cr[3:2];
        r = cr[1:0];
        case (turns)
            2'd0:    return {c, r};
            2'd1:    return {2'd3 - r, c};
            2'd2:    return {2'd3 - c, 2'd3 - r};
            default: return {r, 2'd3 - c};
        endcase
    endfunction

    // Returns {hit, in_edge_band} for one pixel against one cell.
    function automatic logic [1:0] classify(input logic [XW-1:0] ax, input logic [XW-1:0] ay,
                                            input cell_t c);
        logic in_x;
        logic in_y;
        logic band;
        in_x = (ax >= c.x0) && (ax <= c.x0 + XW'(SIZE - 1));
        in_y = (ay >= c.y0) && (ay <= c.y0 + XW'(SIZE - 1));
        band = (ax < c.x0 + XW'(EDGE)) || (ax > c.x0 + XW'(SIZE - 1 - EDGE)) ||
               (ay < c.y0 + XW'(EDGE)) || (ay > c.y0 + XW'(SIZE - 1 - EDGE));
        return {c.vld && in_x && in_y, band};
    endfunction

    // State register (also holds all datapath flops).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            k_q            <= '0;
            piece_q        <= '0;
            rot_q          <= '0;
            ref_x_q        <= '0;
            ref_y_q        <= '0;
            // NOTE: the cell sets are only 4 entries, so they are reset like ordinary flops;
            // a reset that leaves stale origins could otherwise paint ghost cells.
            shadow_q       <= '0;
            active_q       <= '0;
            active_valid_q <= 1'b0;
            done_q         <= 1'b0;
            hit_q          <= '0;
            bnd_q          <= '0;
            en_inner_q     <= 1'b0;
            en_edge_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge values,
            // so ordering within this block cannot create a race.
            state_q        <= state_d;
            k_q            <= k_d;
            piece_q        <= piece_d;
            rot_q          <= rot_d;
            ref_x_q        <= ref_x_d;
            ref_y_q        <= ref_y_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            active_valid_q <= active_valid_d;
            done_q         <= done_d;
            hit_q          <= hit_d;
            bnd_q          <= bnd_d;
            en_inner_q     <= en_inner_d;
            en_edge_q      <= en_edge_d;
        end
    end

    // Next-state logic: a load always wins and restarts the build from cell 0.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        k_d     = k_q;
        commit  = 1'b0;
        case (state_q)
            BUILD: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    commit  = 1'b1;
                    state_d = ACTIVE;
                end
            end
            default: ;
        endcase
        if (load) begin
            state_d = BUILD;
            k_d     = 2'd0;
        end
    end

    // Build datapath: one cell per BUILD cycle, the last cell joins the commit directly.
    always_comb begin
        logic [3:0] cr;
        cr           = rotate(base_cell(piece_q, k_q), rot_q);
        new_cell.vld = (piece_q != 3'd7);
        new_cell.x0  = XW'(ref_x_q) + XW'(cr[3:2]) * XW'(SIZE);
        new_cell.y0  = XW'(ref_y_q) + XW'(cr[1:0]) * XW'(SIZE);

        piece_d = load ? piece : piece_q;
        rot_d   = load ? rot   : rot_q;
        ref_x_d = load ? ref_x : ref_x_q;
        ref_y_d = load ? ref_y : ref_y_q;

        shadow_d = shadow_q;
        if (state_q == BUILD) shadow_d[k_q] = new_cell;

        active_d       = active_q;
        active_valid_d = active_valid_q;
        if (commit) begin
            active_d       = shadow_d;
            active_valid_d = 1'b1;
        end
        done_d = commit;
    end

    // Pixel pipeline: stage 1 per-cell flags, stage 2 OR-reduction.
    always_comb begin
        logic [1:0] cls;
        hit_d = '0;
        bnd_d = '0;
        for (int i = 0; i < 4; i++) begin
            cls      = classify(XW'(addr_x), XW'(addr_y), active_q[i]);
            hit_d[i] = active_valid_q && cls[1];
            bnd_d[i] = active_valid_q && cls[1] && cls[0];
        end
        en_inner_d = |(hit_q & ~bnd_q);
        en_edge_d  = |bnd_q;
    end

    // Output logic.
    always_comb begin
        busy     = (state_q == BUILD);
        done     = done_q;
        en_inner = en_inner_q;
        en_edge  = en_edge_q;
    end

endmodule

// File: tb/tb_tetromino_render.sv
// Directed self-checking bench for tetromino_render: build timing, restart, reset abort,
// rotation and edge/inner classification with hand-computed pixel expectations.
module tb_tetromino_render;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [2:0] piece;
    logic [1:0] rot;
    logic [9:0] ref_x, ref_y, addr_x, addr_y;
    logic       en_inner, en_edge, busy, done;

    int n_asserts = 0;
    int n_fail    = 0;

    tetromino_render #(.SIZE(16), .EDGE(1), .COORD_W(10)) dut (
        .clk(clk), .reset(reset), .load(load), .piece(piece), .rot(rot),
        .ref_x(ref_x), .ref_y(ref_y), .addr_x(addr_x), .addr_y(addr_y),
        .en_inner(en_inner), .en_edge(en_edge), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic exp_in, input logic exp_ed);
        addr_x = 10'(x);
        addr_y = 10'(y);
        tick();
        tick();
        check({tag, " inner"}, {31'd0, en_inner}, {31'd0, exp_in});
        check({tag, " edge"},  {31'd0, en_edge},  {31'd0, exp_ed});
    endtask

    task automatic load_and_build(input string tag, input logic [2:0] p, input logic [1:0] r,
                                  input int x, input int y);
        piece = p;
        rot   = r;
        ref_x = 10'(x);
        ref_y = 10'(y);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        check({tag, " busy N"}, {31'd0, busy}, 32'd1);
        check({tag, " done N"}, {31'd0, done}, 32'd0);
        repeat (3) begin
            tick();
            check({tag, " busy build"}, {31'd0, busy}, 32'd1);
            check({tag, " done build"}, {31'd0, done}, 32'd0);
        end
        tick();
        check({tag, " busy commit"}, {31'd0, busy}, 32'd0);
        check({tag, " done commit"}, {31'd0, done}, 32'd1);
        tick();
        check({tag, " done after"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        piece  = 3'd0;
        rot    = 2'd0;
        ref_x  = '0;
        ref_y  = '0;
        addr_x = 10'd117;
        addr_y = 10'd201;
        #2;
        check("reset busy",  {31'd0, busy},     32'd0);
        check("reset done",  {31'd0, done},     32'd0);
        check("reset inner", {31'd0, en_inner}, 32'd0);
        check("reset edge",  {31'd0, en_edge},  32'd0);
        tick();
        reset = 1'b0;

        // No load yet: nothing may be drawn.
        pix("idle 117,201", 117, 201, 1'b0, 1'b0);
        pix("idle 0,0",       0,   0, 1'b0, 1'b0);
        pix("idle 40,56",    40,  56, 1'b0, 1'b0);
        check("idle busy", {31'd0, busy}, 32'd0);
        check("idle done", {31'd0, done}, 32'd0);

        // T rot0 at (100,200): cells at x0 {116,100,116,132}, y0 {200,216,216,216}.
        load_and_build("T r0", 3'd2, 2'd0, 100, 200);
        pix("T 117,201", 117, 201, 1'b1, 1'b0);
        pix("T 116,205", 116, 205, 1'b0, 1'b1);
        pix("T 100,200", 100, 200, 1'b0, 1'b0);
        pix("T 131,215", 131, 215, 1'b0, 1'b1);
        pix("T 140,220", 140, 220, 1'b1, 1'b0);

        // I rot1 at origin: column at x 32..47, y 0..63.
        load_and_build("I r1", 3'd0, 2'd1, 0, 0);
        pix("I1 40,56", 40, 56, 1'b1, 1'b0);
        pix("I1 40,8",  40,  8, 1'b1, 1'b0);
        pix("I1 8,24",   8, 24, 1'b0, 1'b0);
        pix("I1 47,63", 47, 63, 1'b0, 1'b1);

        // I rot3 at origin: column at x 16..31.
        load_and_build("I r3", 3'd0, 2'd3, 0, 0);
        pix("I3 24,8",  24, 8, 1'b1, 1'b0);
        pix("I3 40,8",  40, 8, 1'b0, 1'b0);

        // Restart two cycles into a build; (24,8) stays lit until the second build commits.
        addr_x = 10'd24;
        addr_y = 10'd8;
        piece = 3'd2; rot = 2'd0; ref_x = 10'd100; ref_y = 10'd200;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("rs busy N", {31'd0, busy}, 32'd1);
        tick();
        check("rs busy N1",  {31'd0, busy},     32'd1);
        check("rs inner N1", {31'd0, en_inner}, 32'd1);
        piece = 3'd0; rot = 2'd1; ref_x = 10'd0; ref_y = 10'd0;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("rs busy M", {31'd0, busy}, 32'd1);
        check("rs done M", {31'd0, done}, 32'd0);
        repeat (3) begin
            tick();
            check("rs busy build",  {31'd0, busy},     32'd1);
            check("rs done build",  {31'd0, done},     32'd0);
            check("rs inner build", {31'd0, en_inner}, 32'd1);
        end
        tick();
        check("rs busy commit", {31'd0, busy}, 32'd0);
        check("rs done commit", {31'd0, done}, 32'd1);
        tick();
        check("rs done after",  {31'd0, done},     32'd0);
        check("rs inner M5",    {31'd0, en_inner}, 32'd1);
        tick();
        check("rs inner M6",    {31'd0, en_inner}, 32'd0);
        pix("rs 40,8", 40, 8, 1'b1, 1'b0);

        // Reset in the middle of a build aborts it and blanks the display.
        piece = 3'd2; rot = 2'd0; ref_x = 10'd100; ref_y = 10'd200;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("rb busy pre",  {31'd0, busy},     32'd1);
        check("rb inner pre", {31'd0, en_inner}, 32'd1);
        reset = 1'b1;
        #1;
        check("rb busy",  {31'd0, busy},     32'd0);
        check("rb done",  {31'd0, done},     32'd0);
        check("rb inner", {31'd0, en_inner}, 32'd0);
        check("rb edge",  {31'd0, en_edge},  32'd0);
        tick();
        tick();
        reset = 1'b0;
        repeat (6) begin
            tick();
            check("rb busy post", {31'd0, busy}, 32'd0);
            check("rb done post", {31'd0, done}, 32'd0);
        end
        pix("rb 40,8",    40,   8, 1'b0, 1'b0);
        pix("rb 117,201", 117, 201, 1'b0, 1'b0);

        // O at (1020,1020): origins beyond 1023 must not alias to low coordinates.
        load_and_build("O wrap", 3'd1, 2'd0, 1020, 1020);
        pix("wrap 14,14",     14,   14, 1'b0, 1'b0);
        pix("wrap 20,20",     20,   20, 1'b0, 1'b0);
        pix("wrap 0,0",        0,    0, 1'b0, 1'b0);
        pix("wrap 1023,1023", 1023, 1023, 1'b0, 1'b0);

        // Empty piece at origin never hits.
        load_and_build("empty", 3'd7, 2'd0, 0, 0);
        pix("empty 4,4",   4,  4, 1'b0, 1'b0);
        pix("empty 20,4", 20,  4, 1'b0, 1'b0);
        pix("empty 8,24",  8, 24, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/tetromino_render.md
Name: tetromino_render

Overview:
- Parametrised successor to the per-shape pixel hit-testers.
- Renders any of the 7 tetrominoes in any of 4 rotations.
- A load strobe latches piece, rotation and anchor. A 4-cycle build FSM computes the cell origins into a shadow set and commits them atomically.
- A 2-stage registered pipeline classifies each VGA pixel address as inner, edge or miss against the committed set. Sits between the game-state logic and the VGA colour mux.

Parameters:
- SIZE, 16, cell side in pixels (4..64).
- EDGE, 1, edge band width in pixels (1..SIZE/2-1).
- COORD_W, 10, pixel coordinate width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  one-cycle strobe; latch piece/rot/ref_x/ref_y
- piece  in  3  0=I 1=O 2=T 3=S 4=Z 5=J 6=L 7=empty
- rot  in  2  clockwise quarter-turns
- ref_x  in  COORD_W  anchor x (top-left of 4x4 grid)
- ref_y  in  COORD_W  anchor y
- addr_x  in  COORD_W  current pixel x
- addr_y  in  COORD_W  current pixel y
- en_inner  out  1  pixel inside an occupied cell, outside edge band
- en_edge  out  1  pixel inside an occupied cell's edge band
- busy  out  1  build in progress
- done  out  1  one-cycle pulse on commit

Behaviour:
- Reset (async, active-high):
  - State IDLE, active_valid=0, all cell registers 0.
  - en_inner=en_edge=busy=done=0.
- Rotation-0 cells (col,row) in the 4x4 grid:
  - I: (0,1)(1,1)(2,1)(3,1)
  - O: (1,0)(2,0)(1,1)(2,1)
  - T: (1,0)(0,1)(1,1)(2,1)
  - S: (1,0)(2,0)(0,1)(1,1)
  - Z: (0,0)(1,0)(1,1)(2,1)
  - J: (0,0)(0,1)(1,1)(2,1)
  - L: (2,0)(0,1)(1,1)(2,1)
  - Piece 7 marks all four cells empty (never hit).
- Each quarter-turn maps (col,row) -> (3-row, col), applied rot times.
- Cell origin: x0=ref_x+col*SIZE, y0=ref_y+row*SIZE. Computed in COORD_W+2 unsigned bits, no wrap; cells past the screen simply never match.
- FSM states IDLE, BUILD, ACTIVE:
  - load sampled at edge N in any state: latch inputs, enter BUILD, cell index k=0.
  - In BUILD, edges N+1..N+4 write shadow cell k=0..3.
  - Edge N+4: shadow copied to active set, active_valid=1, state ACTIVE.
  - busy=1 from edge N through edge N+4 (4 cycles). done=1 for the single cycle after edge N+4.
  - load during BUILD restarts from k=0 with the new inputs. The partial shadow is discarded, the old active set stays displayed, and no done is produced for the aborted build.
  - load coinciding with commit edge N+4: the commit happens and the restart wins (busy stays 1, done=1 for that cycle).
- Pixel pipeline (independent of FSM, always running):
  - Stage 1 (edge T): register addr and per-cell hit/edge flags against the active set at edge T.
  - Stage 2 (edge T+1): OR-reduce and register outputs.
  - Latency exactly 2 cycles; full throughput, one pixel per clock.
- Cell hit: x0<=addr_x<=x0+SIZE-1 and y0<=addr_y<=y0+SIZE-1.
  - Edge: hit and (addr_x<x0+EDGE or addr_x>x0+SIZE-1-EDGE or same in y).
  - Inner: hit and not edge.
  - Cells never overlap, so en_inner and en_edge are mutually exclusive.
  - active_valid=0 forces both to 0.
- Reset mid-build: aborts immediately. Active set cleared, outputs 0 on the next sampled pixel; pipeline registers cleared asynchronously.

Test Plan:
- Reset, no load, sweep pixels -> en_inner=en_edge=0 throughout; busy=0, done=0.
- Load T rot0, ref=(100,200), SIZE=16, EDGE=1 -> busy for 4 cycles, then done pulse.
  - Pixel (117,201): en_inner=1 two cycles after presentation.
  - (116,205): en_edge=1.
  - (100,200): both 0.
  - (131,215): en_edge=1.
- Load I rot1, ref=(0,0) -> vertical column at col2.
  - (40,56) inner; (40,8) inner; (8,24) miss.
  - Rot3 gives column col1: (24,8) inner.
- Second load 2 cycles into a build -> busy stays high 4 cycles after the second load, single done pulse, old shape displayed until commit.
- Assert reset during BUILD -> busy, done and outputs 0 within one cycle. No commit after reset release.
- ref=(1020,1020), piece O -> no false hits at low coordinates (wrap check); piece 7 -> no hits anywhere.
